// File: rtl/mire_pkg.sv
// Shared types and Wishbone constants for the frame-buffer test-pattern writer.
package mire_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0]  WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0]  WB_BTE_LINEAR  = 2'b00;
    localparam logic [23:0] GRID_COLOUR    = 24'hFFFFFF;

endpackage

// File: rtl/mire_pixel_gen.sv
// Combinational test-pattern colour: white grid every STRIPE pixels,
// otherwise a colour built from frame number and pixel coordinates.
module mire_pixel_gen
    import mire_pkg::*;
#(
    parameter int XW     = 10,
    parameter int YW     = 9,
    parameter int STRIPE = 16
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [7:0]    frame_lsb,
    output logic [31:0]   pixel
);

    localparam logic [31:0] STRIPE_MASK = 32'(STRIPE - 1);

    logic [31:0] x32;
    logic [31:0] y32;
    logic        on_grid;

    assign x32 = 32'(x);
    assign y32 = 32'(y);

    // STRIPE is a power of two, so the modulo reduces to a mask
    assign on_grid = ((x32 & STRIPE_MASK) == 32'd0) || ((y32 & STRIPE_MASK) == 32'd0);

    assign pixel = on_grid ? {8'h00, GRID_COLOUR}
                           : {8'h00, frame_lsb, x32[7:0], y32[7:0]};

endmodule

// File: rtl/wshb_mire_writer.sv
// Wishbone classic-cycle initiator that writes the mire test pattern into the
// SDRAM frame buffer, one pixel per write, refilling frames while enabled.
//
// state | meaning
// IDLE  | waiting for enable with no latched error
// REQ   | cyc/stb asserted for the current pixel, waiting for ack/rty/err
// GAP   | cyc released for one cycle (burst limit reached or retry)
// DONE  | last pixel acked; frame_done pulse
module wshb_mire_writer
    import mire_pkg::*;
#(
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480,
    parameter logic [31:0] BASE_ADR  = 32'h0,
    parameter int          STRIPE    = 16,
    parameter int          BURST_MAX = 64
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        enable,
    output logic [31:0] adr,
    output logic [31:0] dat_ms,
    output logic        we,
    output logic [3:0]  sel,
    output logic        stb,
    output logic        cyc,
    output logic [2:0]  cti,
    output logic [1:0]  bte,
    input  logic        ack,
    input  logic        err,
    input  logic        rty,
    output logic        busy,
    output logic        frame_done,
    output logic        err_flag,
    output logic [15:0] frame_cnt
);

    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int BW = $clog2(BURST_MAX + 1);

    localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BURST_MAX - 1);

    state_t        state, state_nxt;
    logic [XW-1:0] x, x_nxt;
    logic [YW-1:0] y, y_nxt;
    logic [31:0]   adr_r, adr_nxt;
    logic [BW-1:0] burst_cnt, burst_nxt;
    logic          err_nxt;
    logic [15:0]   fcnt_nxt;
    logic [31:0]   pixel;
    logic          req;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            adr_r     <= BASE_ADR;
            burst_cnt <= '0;
            err_flag  <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            state     <= state_nxt;
            x         <= x_nxt;
            y         <= y_nxt;
            adr_r     <= adr_nxt;
            burst_cnt <= burst_nxt;
            err_flag  <= err_nxt;
            frame_cnt <= fcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        adr_nxt   = adr_r;
        burst_nxt = burst_cnt;
        err_nxt   = err_flag;
        fcnt_nxt  = frame_cnt;
        case (state)
            IDLE: begin
                if (enable && !err_flag) begin
                    state_nxt = REQ;
                    x_nxt     = '0;
                    y_nxt     = '0;
                    adr_nxt   = BASE_ADR;
                    burst_nxt = '0;
                end
            end
            REQ: begin
                // ack wins over rty, rty over err
                if (ack) begin
                    if (x == X_LAST && y == Y_LAST) begin
                        state_nxt = DONE;
                        fcnt_nxt  = frame_cnt + 16'd1;
                    end else begin
                        adr_nxt = adr_r + 32'd4;
                        if (x == X_LAST) begin
                            x_nxt = '0;
                            y_nxt = y + 1'b1;
                        end else begin
                            x_nxt = x + 1'b1;
                        end
                        if (burst_cnt == B_LAST) begin
                            state_nxt = GAP;
                            burst_nxt = '0;
                        end else begin
                            burst_nxt = burst_cnt + 1'b1;
                        end
                    end
                end else if (rty) begin
                    state_nxt = GAP;
                    burst_nxt = '0;
                end else if (err) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            GAP:     state_nxt = REQ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    mire_pixel_gen #(
        .XW     (XW),
        .YW     (YW),
        .STRIPE (STRIPE)
    ) u_pixel_gen (
        .x         (x),
        .y         (y),
        .frame_lsb (frame_cnt[7:0]),
        .pixel     (pixel)
    );

    assign req        = (state == REQ);
    assign cyc        = req;
    assign stb        = req;
    assign we         = req;
    assign sel        = req ? 4'hF : 4'h0;
    assign adr        = req ? adr_r : 32'd0;
    assign dat_ms     = req ? pixel : 32'd0;
    assign cti        = WB_CTI_CLASSIC;
    assign bte        = WB_BTE_LINEAR;
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

endmodule

// File: tb/tb_wshb_mire_writer.sv
// Self-checking bench for wshb_mire_writer with a small 8x4 frame: a Wishbone
// responder with optional random wait states, retry and error injection.
module tb_wshb_mire_writer;

    localparam int          H    = 8;
    localparam int          V    = 4;
    localparam int          STR  = 4;
    localparam int          BM   = 5;
    localparam int          NPIX = H * V;
    localparam logic [31:0] BASE = 32'h0;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        enable;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic        rty;
    logic        busy;
    logic        frame_done;
    logic        err_flag;
    logic [15:0] frame_cnt;

    wshb_mire_writer #(
        .HDISP     (H),
        .VDISP     (V),
        .BASE_ADR  (BASE),
        .STRIPE    (STR),
        .BURST_MAX (BM)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .enable     (enable),
        .adr        (adr),
        .dat_ms     (dat_ms),
        .we         (we),
        .sel        (sel),
        .stb        (stb),
        .cyc        (cyc),
        .cti        (cti),
        .bte        (bte),
        .ack        (ack),
        .err        (err),
        .rty        (rty),
        .busy       (busy),
        .frame_done (frame_done),
        .err_flag   (err_flag),
        .frame_cnt  (frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;

    typedef struct {
        string       name;
        int          idx;
        logic [31:0] adr;
        logic [31:0] dat;
    } vec_t;

    // responder configuration (written by the main sequence only)
    bit rand_mode = 1'b0;
    int rty_at    = 0;
    int err_at    = 0;

    // responder/monitor observations (written by those processes only)
    wr_t         ack_q[$];
    logic [31:0] att_adr[$];
    int          stab_viol = 0;
    int          done_cnt  = 0;
    int          cyc_cnt   = 0;
    int          post_rty  = 0;
    logic        gap_c0    = 1'b1;
    logic        gap_c1    = 1'b0;

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] exp_pix(int x, int y, int fc);
        if (x % STR == 0 || y % STR == 0) return 32'h00FF_FFFF;
        return {8'h00, 8'(fc), 8'(x), 8'(y)};
    endfunction

    function automatic logic [31:0] exp_adr(int i);
        return BASE + 32'(4 * i);
    endfunction

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic cmp_frame(input string name, input int base, input int fc);
        int bad = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (base + i >= ack_q.size()) bad++;
            else if (ack_q[base+i].adr !== exp_adr(i) ||
                     ack_q[base+i].dat !== exp_pix(i % H, i / H, fc)) bad++;
        end
        chk(name, 64'(bad), 64'd0);
    endtask

    // Wishbone responder: sampled/driven on the falling edge
    initial begin
        bit in_xfer = 1'b0;
        int wait_left = 0;
        logic [31:0] hold_adr = '0;
        logic [31:0] hold_dat = '0;
        ack = 1'b0;
        rty = 1'b0;
        err = 1'b0;
        forever begin
            @(negedge sys_clk);
            ack = 1'b0;
            rty = 1'b0;
            err = 1'b0;
            if (post_rty == 1) begin
                gap_c0   = cyc;
                post_rty = 2;
            end else if (post_rty == 2) begin
                gap_c1   = cyc;
                post_rty = 0;
            end
            if (cyc && stb && !sys_rst) begin
                if (!in_xfer) begin
                    in_xfer   = 1'b1;
                    wait_left = rand_mode ? int'($urandom_range(0, 7)) : 0;
                    hold_adr  = adr;
                    hold_dat  = dat_ms;
                end else if (adr !== hold_adr || dat_ms !== hold_dat) begin
                    stab_viol++;
                end
                if (wait_left == 0) begin
                    att_adr.push_back(adr);
                    if (att_adr.size() == rty_at) begin
                        rty      = 1'b1;
                        post_rty = 1;
                    end else if (att_adr.size() == err_at) begin
                        err = 1'b1;
                    end else begin
                        ack = 1'b1;
                        ack_q.push_back('{adr, dat_ms});
                    end
                    in_xfer = 1'b0;
                end else begin
                    wait_left--;
                end
            end else begin
                in_xfer = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge sys_clk);
            if (frame_done) done_cnt++;
            if (cyc) cyc_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        vec_t vecs[6];
        logic exp_cyc[$];
        int   a0, a1, t0, d0, c0, sv0, n, mism, mism_ctl;

        vecs[0] = '{"px_0_0",  0,  32'h00, 32'h00FF_FFFF};
        vecs[1] = '{"px_1_1",  9,  32'h24, 32'h0000_0101};
        vecs[2] = '{"px_3_1",  11, 32'h2C, 32'h0000_0301};
        vecs[3] = '{"px_4_2",  20, 32'h50, 32'h00FF_FFFF};
        vecs[4] = '{"px_5_3",  29, 32'h74, 32'h0000_0503};
        vecs[5] = '{"px_7_3",  31, 32'h7C, 32'h0000_0703};

        // 1: reset state, idle with enable low
        sys_rst = 1'b1;
        enable  = 1'b0;
        repeat (3) tick();
        chk("rst_adr", 64'(adr), 64'd0);
        chk("rst_dat", 64'(dat_ms), 64'd0);
        chk("rst_ctrl", 64'({we, sel, stb, cyc, cti, bte, busy, frame_done, err_flag}), 64'd0);
        chk("rst_fcnt", 64'(frame_cnt), 64'd0);
        sys_rst = 1'b0;
        c0 = cyc_cnt;
        repeat (100) tick();
        chk("idle_no_cyc", 64'(cyc_cnt - c0), 64'd0);

        // 2: ack tied high, one full frame
        for (int k = 1; k <= NPIX; k++) begin
            exp_cyc.push_back(1'b1);
            if (k % BM == 0 && k != NPIX) exp_cyc.push_back(1'b0);
        end
        a0 = ack_q.size();
        d0 = done_cnt;
        enable = 1'b1;
        tick();
        mism = 0;
        mism_ctl = 0;
        for (int i = 0; i < exp_cyc.size(); i++) begin
            if (cyc !== exp_cyc[i]) mism++;
            if ({stb, we, sel} !== (exp_cyc[i] ? 6'b11_1111 : 6'b00_0000)) mism_ctl++;
            tick();
        end
        chk("t2_cyc_pattern", 64'(mism), 64'd0);
        chk("t2_stb_we_sel", 64'(mism_ctl), 64'd0);
        chk("t2_done_pulse", 64'({frame_done, cyc}), 64'b10);
        enable = 1'b0;
        repeat (5) tick();
        chk("t2_done_count", 64'(done_cnt - d0), 64'd1);
        chk("t2_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("t2_writes", 64'(ack_q.size() - a0), 64'(NPIX));
        for (int i = 0; i < 6; i++) begin
            chk({vecs[i].name, "_adr"}, 64'(ack_q[a0 + vecs[i].idx].adr), 64'(vecs[i].adr));
            chk({vecs[i].name, "_dat"}, 64'(ack_q[a0 + vecs[i].idx].dat), 64'(vecs[i].dat));
        end
        cmp_frame("t2_frame", a0, 0);

        // 3: random wait states, two frames, enable dropped mid second frame
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        rand_mode = 1'b1;
        a0  = ack_q.size();
        d0  = done_cnt;
        sv0 = stab_viol;
        enable = 1'b1;
        wait_done(1500, "t3_frame0_done");
        n = 0;
        while (!cyc && n < 20) begin
            tick();
            n++;
        end
        chk("t3_restart", 64'(cyc), 64'd1);
        enable = 1'b0;
        wait_done(1500, "t3_frame1_done");
        repeat (20) tick();
        cmp_frame("t3_frame0", a0, 0);
        cmp_frame("t3_frame1", a0 + NPIX, 1);
        chk("t3_px11_f1", 64'(ack_q[a0 + NPIX + 9].dat), 64'h0001_0101);
        chk("t3_stable", 64'(stab_viol - sv0), 64'd0);
        chk("t3_frames", 64'(done_cnt - d0), 64'd2);
        chk("t3_frame_cnt", 64'(frame_cnt), 64'd2);

        // 4: retry on write #10
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        rand_mode = 1'b0;
        a0 = ack_q.size();
        t0 = att_adr.size();
        rty_at = t0 + 10;
        enable = 1'b1;
        wait_done(300, "t4_done");
        enable = 1'b0;
        repeat (5) tick();
        rty_at = 0;
        chk("t4_acks", 64'(ack_q.size() - a0), 64'(NPIX));
        chk("t4_attempts", 64'(att_adr.size() - t0), 64'(NPIX + 1));
        chk("t4_rty_adr", 64'(att_adr[t0 + 9]), 64'h24);
        chk("t4_reissue_adr", 64'(att_adr[t0 + 10]), 64'h24);
        chk("t4_rty_gap", 64'({gap_c0, gap_c1}), 64'b01);
        cmp_frame("t4_frame", a0, 0);

        // 5: error on write #3, frame_cnt stays at 1
        a0 = ack_q.size();
        err_at = att_adr.size() + 3;
        enable = 1'b1;
        n = 0;
        while (!err_flag && n < 50) begin
            tick();
            n++;
        end
        chk("t5_err_flag", 64'(err_flag), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("t5_acks", 64'(ack_q.size() - a0), 64'd2);
        c0 = cyc_cnt;
        repeat (50) tick();
        chk("t5_no_cyc", 64'(cyc_cnt - c0), 64'd0);
        chk("t5_err_sticky", 64'(err_flag), 64'd1);

        // 6: reset mid-frame, restart from BASE with enable held high
        err_at = 0;
        rand_mode = 1'b1;
        sys_rst = 1'b1;
        tick();
        chk("t6_err_cleared", 64'(err_flag), 64'd0);
        sys_rst = 1'b0;
        a0 = ack_q.size();
        n = 0;
        while (!((ack_q.size() - a0) >= 10 && stb) && n < 500) begin
            tick();
            n++;
        end
        chk("t6_mid_frame", 64'(stb), 64'd1);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("t6_async_drop", 64'({cyc, stb}), 64'd0);
        tick();
        t0 = att_adr.size();
        a1 = ack_q.size();
        sys_rst = 1'b0;
        wait_done(1500, "t6_done");
        enable = 1'b0;
        repeat (5) tick();
        chk("t6_first_adr", 64'(att_adr[t0]), 64'(BASE));
        cmp_frame("t6_frame", a1, 0);
        chk("t6_frame_cnt", 64'(frame_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
